// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for one shared 4-way bus mux.
// A registered FSM (IDLE / GRANT / RELEASE) hands out a one-hot grant and a
// 2-bit select. Each tenure is capped at MAX_HOLD cycles, and every tenure is
// followed by one dead bus cycle so two drivers never overlap on the bus.
module bus_arbiter_rr #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8   // legal range 1..255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            last,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            gnt,
  output logic [1:0]            gnt_id,
  output logic                  gnt_valid,
  output logic [DATA_W-1:0]     bus_data,
  output logic                  timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_e      state_q,     state_d;
  logic [3:0]  gnt_q,       gnt_d;
  logic [1:0]  gnt_id_q,    gnt_id_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic [1:0]  prio_ptr_q,  prio_ptr_d;
  logic [7:0]  hold_cnt_q,  hold_cnt_d;
  logic        timeout_q,   timeout_d;

  logic [7:0]  req_dbl;
  logic [3:0]  req_rot;
  logic [1:0]  arb_offset;
  logic [1:0]  arb_winner;
  logic        arb_any;
  logic        owner_req;
  logic        owner_last;

  logic [DATA_W-1:0] lane [4];

  // Split the flat data bus into per-requester lanes.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane[g] = data_in[g*DATA_W +: DATA_W];
  end

  // Rotate req so the current highest-priority requester sits at bit 0, then
  // take the first set bit; adding the pointer back gives the winner index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    arb_offset = 2'd0;
    req_dbl    = {req, req};
    req_rot    = req_dbl[prio_ptr_q +: 4];
    arb_any    = |req;
    if      (req_rot[0]) arb_offset = 2'd0;
    else if (req_rot[1]) arb_offset = 2'd1;
    else if (req_rot[2]) arb_offset = 2'd2;
    else if (req_rot[3]) arb_offset = 2'd3;
    arb_winner = prio_ptr_q + arb_offset;
  end

  // The current owner's own request and last-beat flags; other requesters'
  // signals never influence an ongoing tenure.
  always_comb begin
    owner_req  = req[gnt_id_q];
    owner_last = last[gnt_id_q];
  end

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    prio_ptr_d  = prio_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE, RELEASE: begin
        if (arb_any) begin
          state_d    = GRANT;
          gnt_d      = 4'b0001 << arb_winner;
          gnt_id_d   = arb_winner;
          hold_cnt_d = 8'd1;
          // The winner drops to lowest priority for the next round.
          prio_ptr_d = arb_winner + 2'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end

      GRANT: begin
        if (!owner_req || owner_last) begin
          // Normal end wins over a coincident hold limit.
          state_d = RELEASE;
          gnt_d   = 4'b0000;
        end else if (hold_cnt_q == MAX_HOLD_C) begin
          state_d   = RELEASE;
          gnt_d     = 4'b0000;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase

    gnt_valid_d = |gnt_d;
  end

  // FSM state and all registered outputs; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      prio_ptr_q  <= 2'd0;
      hold_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      prio_ptr_q  <= prio_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Bus mux: the selected lane when a grant is live, otherwise a quiet bus.
  always_comb begin
    bus_data = '0;
    if (gnt_valid_q) bus_data = lane[gnt_id_q];
  end

  assign gnt           = gnt_q;
  assign gnt_id        = gnt_id_q;
  assign gnt_valid     = gnt_valid_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr. Expected outputs are queued when a
// cycle of stimulus is driven and compared after the clock edge that
// produces them.
module tb_bus_arbiter_rr;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 8;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          req   = 4'b0000;
  logic [3:0]          last  = 4'b0000;
  logic [4*DATA_W-1:0] data_in;
  logic [3:0]          gnt;
  logic [1:0]          gnt_id;
  logic                gnt_valid;
  logic [DATA_W-1:0]   bus_data;
  logic                timeout_pulse;

  typedef struct packed {
    logic [3:0]        gnt;
    logic [1:0]        id;
    logic              v;
    logic [DATA_W-1:0] bd;
    logic              to;
  } obs_t;

  obs_t        sb_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [7:0]  lane_val [4];

  bus_arbiter_rr #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .last          (last),
    .data_in       (data_in),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .bus_data      (bus_data),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  function automatic obs_t exp_of(input logic [3:0] g, input logic [1:0] id, input logic to);
    obs_t e;
    e.gnt = g;
    e.id  = id;
    e.v   = |g;
    e.bd  = (|g) ? lane_val[id] : 8'h00;
    e.to  = to;
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.gnt = gnt;
    o.id  = gnt_id;
    o.v   = gnt_valid;
    o.bd  = bus_data;
    o.to  = timeout_pulse;
    return o;
  endfunction

  // One cycle of stimulus: inputs change on the falling edge, the expectation
  // is queued, and the caller samples 1 time unit after the rising edge.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input obs_t e);
    @(negedge clk);
    req  = r;
    last = l;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    last  = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'hF;
    last  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exp_of(4'b0000, 2'd0, 1'b0));
      @(posedge clk);
      #1;
      o = observe();
      e = sb_q.pop_front();
      total_cnt++;
      if (o !== e)
        $display("FAIL reset[%0d]: got gnt=%b id=%0d v=%b bus=%h to=%b, want gnt=%b id=%0d v=%b bus=%h to=%b",
                 i, o.gnt, o.id, o.v, o.bd, o.to, e.gnt, e.id, e.v, e.bd, e.to);
      else pass_cnt++;
    end
    @(negedge clk);
    req   = 4'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] r_tab [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] l_tab [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] g_tab [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(r_tab[i], l_tab[i], exp_of(g_tab[i], 2'd2, 1'b0));
      o = observe();
      e = sb_q.pop_front();
      total_cnt++;
      if (o !== e)
        $display("FAIL single[%0d]: got gnt=%b id=%0d v=%b bus=%h to=%b, want gnt=%b id=%0d v=%b bus=%h to=%b",
                 i, o.gnt, o.id, o.v, o.bd, o.to, e.gnt, e.id, e.v, e.bd, e.to);
      else pass_cnt++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g_tab [11] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                               4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    logic [1:0] id_tab [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      // All requesting with last on every grant cycle; drop requests at the end.
      drive((i < 9) ? 4'hF : 4'h0, (i < 9) ? 4'hF : 4'h0, exp_of(g_tab[i], id_tab[i], 1'b0));
      o = observe();
      e = sb_q.pop_front();
      total_cnt++;
      if (o !== e)
        $display("FAIL rr[%0d]: got gnt=%b id=%0d v=%b bus=%h to=%b, want gnt=%b id=%0d v=%b bus=%h to=%b",
                 i, o.gnt, o.id, o.v, o.bd, o.to, e.gnt, e.id, e.v, e.bd, e.to);
      else pass_cnt++;
    end
  endtask

  // Hold the bus past MAX_HOLD: with a lone requester it is re-granted, with
  // a second requester pending the grant moves on.
  task automatic test_timeout();
    obs_t o, e;
    logic [3:0] r;
    for (int pass = 0; pass < 2; pass++) begin
      r = (pass == 0) ? 4'b0001 : 4'b0011;
      apply_reset();
      for (int i = 0; i < MAX_HOLD + 4; i++) begin
        if (i < MAX_HOLD)
          e = exp_of(4'b0001, 2'd0, 1'b0);
        else if (i == MAX_HOLD)
          e = exp_of(4'b0000, 2'd0, 1'b1);
        else if (i == MAX_HOLD + 1)
          e = (pass == 0) ? exp_of(4'b0001, 2'd0, 1'b0) : exp_of(4'b0010, 2'd1, 1'b0);
        else
          e = (pass == 0) ? exp_of(4'b0000, 2'd0, 1'b0) : exp_of(4'b0000, 2'd1, 1'b0);
        drive((i < MAX_HOLD + 2) ? r : 4'b0000, 4'b0000, e);
        o = observe();
        e = sb_q.pop_front();
        total_cnt++;
        if (o !== e)
          $display("FAIL timeout%0d[%0d]: got gnt=%b id=%0d v=%b bus=%h to=%b, want gnt=%b id=%0d v=%b bus=%h to=%b",
                   pass, i, o.gnt, o.id, o.v, o.bd, o.to, e.gnt, e.id, e.v, e.bd, e.to);
        else pass_cnt++;
      end
    end
  endtask

  // last arrives on the MAX_HOLD-th grant cycle: a normal end, no timeout.
  task automatic test_coincident();
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < MAX_HOLD + 2; i++) begin
      if (i < MAX_HOLD) e = exp_of(4'b0001, 2'd0, 1'b0);
      else              e = exp_of(4'b0000, 2'd0, 1'b0);
      drive((i <= MAX_HOLD) ? 4'b0001 : 4'b0000, (i == MAX_HOLD) ? 4'b0001 : 4'b0000, e);
      o = observe();
      e = sb_q.pop_front();
      total_cnt++;
      if (o !== e)
        $display("FAIL coincident[%0d]: got gnt=%b id=%0d v=%b bus=%h to=%b, want gnt=%b id=%0d v=%b bus=%h to=%b",
                 i, o.gnt, o.id, o.v, o.bd, o.to, e.gnt, e.id, e.v, e.bd, e.to);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin
        drive(4'b1000, 4'b0000, exp_of(4'b1000, 2'd3, 1'b0));
      end else if (i == 2) begin
        // Asynchronous reset between edges must clear the grant at once.
        #2;
        rst_n = 1'b0;
        req   = 4'b0000;
        sb_q.push_back(exp_of(4'b0000, 2'd0, 1'b0));
        #1;
      end else if (i == 3) begin
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1001, 4'b0000, exp_of(4'b0001, 2'd0, 1'b0));
      end else begin
        drive(4'b0000, 4'b0000, exp_of(4'b0000, 2'd0, 1'b0));
      end
      o = observe();
      e = sb_q.pop_front();
      total_cnt++;
      if (o !== e)
        $display("FAIL reset_mid[%0d]: got gnt=%b id=%0d v=%b bus=%h to=%b, want gnt=%b id=%0d v=%b bus=%h to=%b",
                 i, o.gnt, o.id, o.v, o.bd, o.to, e.gnt, e.id, e.v, e.bd, e.to);
      else pass_cnt++;
    end
  endtask

  initial begin
    lane_val[0] = 8'hC3;
    lane_val[1] = 8'h5A;
    lane_val[2] = 8'hA5;
    lane_val[3] = 8'h3C;
    data_in = {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincident();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
